scan_chain_ctrl: RTL and testbench

- Drives one serial scan chain of CHAIN_LEN scan flops.
- The scan flops have a scan-enable input, a scan-in input and a scan-out output that mirrors q.
- Sequence per test: load a parallel test vector serially into the chain, pulse one functional capture cycle, unload the captured response serially and present it in parallel.
- Sits between the test/BIST sequencer and the scan flops. It is the driver of se/si and the consumer of the chain's so.

---
 rtl/scan_chain_ctrl.sv | 130 +++++++++++++
 tb/tb_scan_chain_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_ctrl.sv
// Load / capture / unload controller for a single serial scan chain.
// Define SCAN_CHAIN_CTRL_CMP_EN to add masked response comparison (exp_in, mask_in, mismatch).
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] vec_in,
    output logic                 busy,
    output logic                 se,
    output logic                 si,
    input  logic                 so_in,
    output logic [CHAIN_LEN-1:0] resp_out,
    output logic                 done
`ifdef SCAN_CHAIN_CTRL_CMP_EN
    ,
    input  logic [CHAIN_LEN-1:0] exp_in,
    input  logic [CHAIN_LEN-1:0] mask_in,
    output logic                 mismatch
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [CHAIN_LEN-1:0] shift_reg;
    logic [CHAIN_LEN-1:0] resp_next;
    logic                 last_cnt;

    // The same register serialises the vector out MSB first and collects the
    // response MSB first, since so_in delivers cell CHAIN_LEN-1 first.
    assign resp_next = {shift_reg[CHAIN_LEN-2:0], so_in};
    assign last_cnt  = (cnt_reg == LAST_CNT);

`ifdef SCAN_CHAIN_CTRL_CMP_EN
    logic [CHAIN_LEN-1:0] exp_reg;
    logic [CHAIN_LEN-1:0] mask_reg;
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            se        <= 1'b0;
            si        <= 1'b0;
            done      <= 1'b0;
            resp_out  <= '0;
            cnt_reg   <= '0;
            shift_reg <= '0;
`ifdef SCAN_CHAIN_CTRL_CMP_EN
            exp_reg   <= '0;
            mask_reg  <= '0;
            mismatch  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= LOAD;
                        busy      <= 1'b1;
                        se        <= 1'b1;
                        si        <= vec_in[CHAIN_LEN-1];
                        shift_reg <= vec_in;
                        cnt_reg   <= '0;
`ifdef SCAN_CHAIN_CTRL_CMP_EN
                        exp_reg   <= exp_in;
                        mask_reg  <= mask_in;
`endif
                    end
                end
                LOAD: begin
                    if (last_cnt) begin
                        state_reg <= CAPTURE;
                        se        <= 1'b0;
                        si        <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        si        <= shift_reg[CHAIN_LEN-2];
                        shift_reg <= {shift_reg[CHAIN_LEN-2:0], 1'b0};
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    state_reg <= UNLOAD;
                    se        <= 1'b1;
                    si        <= 1'b0;
                    cnt_reg   <= '0;
                end
                UNLOAD: begin
                    shift_reg <= resp_next;
                    if (last_cnt) begin
                        state_reg <= DONE;
                        se        <= 1'b0;
                        done      <= 1'b1;
                        resp_out  <= resp_next;
                        cnt_reg   <= '0;
`ifdef SCAN_CHAIN_CTRL_CMP_EN
                        mismatch  <= |((resp_next ^ exp_reg) & ~mask_reg);
`endif
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    se        <= 1'b0;
                    si        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: 8-cell and 2-cell chains whose functional d is ~q.
// Expected responses are queued at start and compared when done pulses.
module tb_scan_chain_ctrl;
    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_l;
    logic         start;
    logic [N-1:0] vec_in;
    logic         busy, se, si, so_in, done;
    logic [N-1:0] resp_out;
    logic [N-1:0] chain;

    logic         start2;
    logic [1:0]   vec2;
    logic         busy2, se2, si2, so2, done2;
    logic [1:0]   resp2;
    logic [1:0]   chain2;

`ifdef SCAN_CHAIN_CTRL_CMP_EN
    logic [N-1:0] exp_in, mask_in;
    logic         mismatch;
    logic [1:0]   exp2, mask2;
    logic         mismatch2;
`endif

    scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .start    (start),
        .vec_in   (vec_in),
        .busy     (busy),
        .se       (se),
        .si       (si),
        .so_in    (so_in),
        .resp_out (resp_out),
        .done     (done)
`ifdef SCAN_CHAIN_CTRL_CMP_EN
        ,
        .exp_in   (exp_in),
        .mask_in  (mask_in),
        .mismatch (mismatch)
`endif
    );

    scan_chain_ctrl #(.CHAIN_LEN(2)) dut2 (
        .clk      (clk),
        .rst_l    (rst_l),
        .start    (start2),
        .vec_in   (vec2),
        .busy     (busy2),
        .se       (se2),
        .si       (si2),
        .so_in    (so2),
        .resp_out (resp2),
        .done     (done2)
`ifdef SCAN_CHAIN_CTRL_CMP_EN
        ,
        .exp_in   (exp2),
        .mask_in  (mask2),
        .mismatch (mismatch2)
`endif
    );

    // Scan flop models: shift when se, otherwise capture ~q.
    assign so_in = chain[N-1];
    assign so2   = chain2[1];
    always @(posedge clk) begin
        if (se) chain <= {chain[N-2:0], si};
        else    chain <= ~chain;
        if (se2) chain2 <= {chain2[0], si2};
        else     chain2 <= ~chain2;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [N-1:0] sb[$];
    bit   mon_en = 1'b0;
    logic done_q = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("se_known", 32'($isunknown(se)), 32'd0);
            if (!busy || done) chk("se_low_idle_done", se, 1'b0);
            if (done) chk("done_width", done_q, 1'b0);
            done_q = done;
        end
    end

    task automatic run_seq(input logic [N-1:0] vec, input bit inj, input logic [N-1:0] hold);
        logic [N-1:0] exp_resp;
        exp_resp = 'x;
        start  = 1'b1;
        vec_in = vec;
        sb.push_back(~vec);
        @(posedge clk);
        #1;
        start  = 1'b0;
        vec_in = ~vec;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            chk($sformatf("se_c%0d", c), se, ((c <= 8) || (c >= 10 && c <= 17)));
            if (c <= 8) chk($sformatf("si_c%0d", c), si, vec[N-c]);
            else        chk($sformatf("si_c%0d", c), si, 1'b0);
            chk($sformatf("done_c%0d", c), done, (c == 18));
            chk($sformatf("busy_c%0d", c), busy, (c <= 18));
            if (c < 18) begin
                chk($sformatf("resp_hold_c%0d", c), resp_out, hold);
            end else if (c == 18) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    exp_resp = sb.pop_front();
                    chk("resp", resp_out, exp_resp);
`ifdef SCAN_CHAIN_CTRL_CMP_EN
                    chk("mismatch", mismatch, |((exp_resp ^ exp_in) & ~mask_in));
`endif
                end
                $display("seq vec=%02h resp=%02h expected=%02h", vec, resp_out, exp_resp);
            end else begin
                chk("resp_after_done", resp_out, exp_resp);
            end
            start = inj && (c == 3 || c == 12 || c == 18);
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_l  = 1'b0;
        start  = 1'b0;
        vec_in = '0;
        start2 = 1'b0;
        vec2   = '0;
`ifdef SCAN_CHAIN_CTRL_CMP_EN
        exp_in  = '0;
        mask_in = '0;
        exp2    = '0;
        mask2   = '0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_se", se, 1'b0);
        chk("rst_si", si, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_resp", resp_out, 8'h00);
        @(posedge clk);
        #1;
        rst_l  = 1'b1;
        mon_en = 1'b1;

        run_seq(8'hA5, 1'b0, 8'h00);
        run_seq(8'h00, 1'b0, 8'h5A);
        run_seq(8'hFF, 1'b0, 8'hFF);
        run_seq(8'h96, 1'b1, 8'h00);

        // Abort in UNLOAD cycle 3 (cycle 13 after accept).
        start  = 1'b1;
        vec_in = 8'h3C;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (13) @(negedge clk);
        chk("pre_abort_se", se, 1'b1);
        chk("pre_abort_busy", busy, 1'b1);
        #1;
        rst_l = 1'b0;
        #1;
        chk("abort_se", se, 1'b0);
        chk("abort_si", si, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_resp", resp_out, 8'h00);
        $display("abort vec=3c resp=%02h", resp_out);
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        run_seq(8'hC3, 1'b0, 8'h00);

`ifdef SCAN_CHAIN_CTRL_CMP_EN
        exp_in = 8'h5A; mask_in = 8'h00;
        run_seq(8'hA5, 1'b0, 8'h3C);
        exp_in = 8'h5B; mask_in = 8'h00;
        run_seq(8'hA5, 1'b0, 8'h5A);
        exp_in = 8'h5B; mask_in = 8'h01;
        run_seq(8'hA5, 1'b0, 8'h5A);
`endif

        // Minimum-length chain.
        start2 = 1'b1;
        vec2   = 2'b10;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        vec2   = 2'b01;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk($sformatf("len2_se_c%0d", c), se2, (c == 1 || c == 2 || c == 4 || c == 5));
            chk($sformatf("len2_done_c%0d", c), done2, (c == 6));
            chk($sformatf("len2_busy_c%0d", c), busy2, (c <= 6));
            if (c == 1) chk("len2_si_c1", si2, 1'b1);
            if (c == 2) chk("len2_si_c2", si2, 1'b0);
            if (c == 6) begin
                chk("len2_resp", resp2, 2'b01);
`ifdef SCAN_CHAIN_CTRL_CMP_EN
                chk("len2_mismatch", mismatch2, 1'b1);
`endif
                $display("seq2 vec=10 resp=%b expected=01", resp2);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
